// File: rtl/pool_seq_if.sv
// pool_seq_if: groups the layer-control, feature-buffer read and pool-block
// signals of pool_seq_ctrl into one bundle.
//   master : the sequencer side (pool_seq_ctrl)
//   slave  : the environment side (layer controller, feature buffer, pool block)
// Signals:
//   cfg_start/cfg_pool_en/cfg_layer1/cfg_rows/cfg_cols/cfg_base : layer configuration
//   busy/done/err                                               : layer status
//   rd_en/rd_addr/rd_data                                       : feature buffer read port
//   pool_en/layer1/col/valid_in/data_in/pool_end                : pool block link
interface pool_seq_if #(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 16
);
    logic              cfg_start;
    logic              cfg_pool_en;
    logic              cfg_layer1;
    logic [DIM_W-1:0]  cfg_rows;
    logic [DIM_W-1:0]  cfg_cols;
    logic [ADDR_W-1:0] cfg_base;
    logic              busy;
    logic              done;
    logic              err;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [255:0]      rd_data;
    logic              pool_en;
    logic              layer1;
    logic [15:0]       col;
    logic              valid_in;
    logic [255:0]      data_in;
    logic              pool_end;

    modport master (
        input  cfg_start, cfg_pool_en, cfg_layer1, cfg_rows, cfg_cols, cfg_base,
        input  rd_data, pool_end,
        output busy, done, err, rd_en, rd_addr,
        output pool_en, layer1, col, valid_in, data_in
    );

    modport slave (
        output cfg_start, cfg_pool_en, cfg_layer1, cfg_rows, cfg_cols, cfg_base,
        output rd_data, pool_end,
        input  busy, done, err, rd_en, rd_addr,
        input  pool_en, layer1, col, valid_in, data_in
    );
endinterface

// File: rtl/pool_seq_ctrl.sv
// pool_seq_ctrl: walks a feature map row by row out of the feature buffer and
// hands each row to the max-pool block as one contiguous valid burst, waiting
// for the pool block's end pulse before the next row.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset (aborts a running layer, no done)
//   bus   : pool_seq_if master modport (cfg, status, buffer read, pool link)
module pool_seq_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 16,
    parameter int GAP    = 2,
    parameter int TMO_W  = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    pool_seq_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_WAIT_END,
        S_FINISH
    } state_t;

    localparam int                GAP_W    = $clog2(GAP);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP - 1);
    // Timeout fires in the (2^TMO_W-1)-th cycle counted from GAP entry.
    localparam logic [TMO_W-1:0]  TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
    localparam logic [DIM_W-1:0]  DIM_ONE  = DIM_W'(1);

    state_t            state_q, state_d;
    logic [DIM_W-1:0]  rows_q, rows_d;
    logic [DIM_W-1:0]  cols_q, cols_d;
    logic [DIM_W-1:0]  row_q, row_d;
    logic [DIM_W-1:0]  beat_q, beat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              to_wait_q, to_wait_d;   // GAP exit target: 1 = WAIT_END, 0 = ISSUE
    logic              pend_q, pend_d;         // pool_end seen before WAIT_END
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              pool_en_q, pool_en_d;
    logic              layer1_q, layer1_d;
    logic              valid_q;
    logic              rd_en;

    assign rd_en        = (state_q == S_ISSUE);
    assign bus.rd_en    = rd_en;
    assign bus.rd_addr  = addr_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.pool_en  = pool_en_q;
    assign bus.layer1   = layer1_q;
    assign bus.col      = 16'(cols_q);
    assign bus.valid_in = valid_q;
    // Buffer data arrives one cycle after rd_en, aligned with valid_in.
    assign bus.data_in  = bus.rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rows_q    <= '0;
            cols_q    <= '0;
            row_q     <= '0;
            beat_q    <= '0;
            addr_q    <= '0;
            gap_q     <= '0;
            tmo_q     <= '0;
            to_wait_q <= 1'b0;
            pend_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            pool_en_q <= 1'b0;
            layer1_q  <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            cols_q    <= cols_d;
            row_q     <= row_d;
            beat_q    <= beat_d;
            addr_q    <= addr_d;
            gap_q     <= gap_d;
            tmo_q     <= tmo_d;
            to_wait_q <= to_wait_d;
            pend_q    <= pend_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            done_q    <= done_d;
            pool_en_q <= pool_en_d;
            layer1_q  <= layer1_d;
            valid_q   <= rd_en;
        end
    end

    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        row_d     = row_q;
        beat_d    = beat_q;
        addr_d    = addr_q;
        gap_d     = gap_q;
        tmo_d     = tmo_q;
        to_wait_d = to_wait_q;
        pend_d    = pend_q;
        busy_d    = busy_q;
        err_d     = err_q;
        done_d    = 1'b0;
        pool_en_d = pool_en_q;
        layer1_d  = layer1_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.cfg_start) begin
                    rows_d    = bus.cfg_rows;
                    cols_d    = bus.cfg_cols;
                    pool_en_d = bus.cfg_pool_en;
                    layer1_d  = bus.cfg_layer1;
                    addr_d    = bus.cfg_base;
                    row_d     = '0;
                    beat_d    = '0;
                    pend_d    = 1'b0;
                    busy_d    = 1'b1;
                    err_d     = 1'b0;
                    if (bus.cfg_rows == '0 || bus.cfg_cols == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                addr_d = addr_q + ADDR_W'(1);
                if (bus.pool_end) begin
                    pend_d = 1'b1;
                end
                if (beat_q == cols_q - DIM_ONE) begin
                    state_d   = S_GAP;
                    gap_d     = '0;
                    tmo_d     = '0;
                    to_wait_d = 1'b1;
                end else begin
                    beat_d = beat_q + DIM_ONE;
                end
            end
            S_GAP: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (bus.pool_end) begin
                    pend_d = 1'b1;
                end
                if (gap_q == GAP_LAST) begin
                    state_d = to_wait_q ? S_WAIT_END : S_ISSUE;
                    beat_d  = '0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            S_WAIT_END: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (bus.pool_end || pend_q) begin
                    pend_d = 1'b0;
                    if (row_q == rows_q - DIM_ONE) begin
                        state_d = S_FINISH;
                    end else begin
                        row_d     = row_q + DIM_ONE;
                        state_d   = S_GAP;
                        gap_d     = '0;
                        to_wait_d = 1'b0;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_pool_seq_ctrl.sv
module tb_pool_seq_ctrl;
    localparam int AW = 16;
    localparam int DW = 16;

    logic clk;
    logic rst_n;

    pool_seq_if #(.ADDR_W(AW), .DIM_W(DW)) bus ();

    pool_seq_ctrl #(.ADDR_W(AW), .DIM_W(DW), .GAP(2), .TMO_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [AW-1:0]  addr_q[$];
    logic [255:0]   data_q[$];

    int   exp_cols    = 0;
    int   exp_idle    = 0;
    bit   mon_first   = 1'b1;
    int   run         = 0;
    int   idle        = 0;
    int   burst_cnt   = 0;
    int   done_cnt    = 0;
    int   last_rd_cyc = 0;
    logic prev_rd     = 1'b0;

    int   pe_dly      = 0;
    int   pe_budget   = 0;
    int   pe_cnt      = 0;
    logic prev_vld    = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [255:0] mem_word(input logic [AW-1:0] a);
        return {8{a, ~a}};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_s(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Feature buffer model: data one cycle after rd_en.
    always @(posedge clk) begin
        if (bus.rd_en === 1'b1) bus.rd_data <= mem_word(bus.rd_addr);
        else                    bus.rd_data <= {8{32'hDEADBEEF}};
    end

    // Pool block model: end pulse pe_dly cycles after valid_in falls.
    always @(negedge clk) begin
        bus.pool_end = 1'b0;
        if (prev_vld && bus.valid_in !== 1'b1) begin
            if (pe_dly == 0) begin
                if (pe_budget > 0) begin bus.pool_end = 1'b1; pe_budget--; end
            end else begin
                pe_cnt = pe_dly;
            end
        end else if (pe_cnt > 0) begin
            pe_cnt--;
            if (pe_cnt == 0 && pe_budget > 0) begin bus.pool_end = 1'b1; pe_budget--; end
        end
        prev_vld = (bus.valid_in === 1'b1);
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            prev_rd = 1'b0;
            run     = 0;
            idle    = 0;
        end else begin
            check_s("valid_in_dly", 32'(bus.valid_in), 32'(prev_rd));
            if (bus.rd_en === 1'b1) begin
                if (!prev_rd) begin
                    if (!mon_first) check_s("gap_idle", idle, exp_idle);
                    mon_first = 1'b0;
                    run = 0;
                    burst_cnt++;
                end
                run++;
                last_rd_cyc = cyc;
                check_s("rd_expected", 32'(addr_q.size() > 0), 1);
                if (addr_q.size() > 0) check_s("rd_addr", 32'(bus.rd_addr), 32'(addr_q.pop_front()));
            end else if (prev_rd) begin
                check_s("burst_len", run, exp_cols);
                idle = 1;
            end else begin
                idle++;
            end
            if (bus.valid_in === 1'b1) begin
                check_s("valid_expected", 32'(data_q.size() > 0), 1);
                if (data_q.size() > 0) check("data_in", bus.data_in, data_q.pop_front());
            end
            if (bus.done === 1'b1) done_cnt++;
            prev_rd = (bus.rd_en === 1'b1);
        end
    end

    task automatic start_layer(input logic pe, input logic l1, input int rows, input int cols,
                               input logic [AW-1:0] base, input int push_rows);
        logic [AW-1:0] a;
        for (int r = 0; r < push_rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                a = base + AW'(r * cols + c);
                addr_q.push_back(a);
                data_q.push_back(mem_word(a));
            end
        end
        exp_cols  = cols;
        mon_first = 1'b1;
        @(negedge clk);
        bus.cfg_pool_en = pe;
        bus.cfg_layer1  = l1;
        bus.cfg_rows    = DW'(rows);
        bus.cfg_cols    = DW'(cols);
        bus.cfg_base    = base;
        bus.cfg_start   = 1'b1;
        @(negedge clk);
        bus.cfg_start   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int dcyc);
        bit seen;
        seen = 1'b0;
        dcyc = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                dcyc = cyc;
            end
        end
        check_s({tag, "_done_seen"}, 32'(seen), 1);
    endtask

    task automatic post_done(input string tag, input int d0, input logic exp_err);
        check_s({tag, "_busy_at_done"}, 32'(bus.busy), 0);
        check_s({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        check_s({tag, "_reads_left"}, addr_q.size(), 0);
        check_s({tag, "_data_left"}, data_q.size(), 0);
        @(negedge clk);
        check_s({tag, "_done_one_cycle"}, 32'(bus.done), 0);
        check_s({tag, "_done_count"}, done_cnt - d0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check_s({tag, "_busy"},     32'(bus.busy), 0);
        check_s({tag, "_done"},     32'(bus.done), 0);
        check_s({tag, "_err"},      32'(bus.err), 0);
        check_s({tag, "_rd_en"},    32'(bus.rd_en), 0);
        check_s({tag, "_valid_in"}, 32'(bus.valid_in), 0);
        check_s({tag, "_pool_en"},  32'(bus.pool_en), 0);
        check_s({tag, "_layer1"},   32'(bus.layer1), 0);
        check_s({tag, "_rd_addr"},  32'(bus.rd_addr), 0);
        check_s({tag, "_col"},      32'(bus.col), 0);
    endtask

    initial begin
        int d0;
        int b0;
        int dcyc;

        bus.cfg_start   = 1'b0;
        bus.cfg_pool_en = 1'b0;
        bus.cfg_layer1  = 1'b0;
        bus.cfg_rows    = '0;
        bus.cfg_cols    = '0;
        bus.cfg_base    = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // rows=4, cols=8, base 0x0100: pool_end 3 cycles after each burst
        d0 = done_cnt; b0 = burst_cnt;
        pe_dly = 3; pe_budget = 4; exp_idle = 7;
        start_layer(1'b1, 1'b0, 4, 8, 16'h0100, 4);
        check_s("t1_first_rd", 32'(bus.rd_en), 1);
        check_s("t1_busy", 32'(bus.busy), 1);
        check_s("t1_col", 32'(bus.col), 8);
        check_s("t1_pool_en", 32'(bus.pool_en), 1);
        wait_done("t1", 400, dcyc);
        check_s("t1_done_latency", dcyc - last_rd_cyc, 7);
        check_s("t1_bursts", burst_cnt - b0, 4);
        post_done("t1", d0, 1'b0);

        // rows=2, cols=1: bypass-style end pulse arrives during GAP
        d0 = done_cnt; b0 = burst_cnt;
        pe_dly = 0; pe_budget = 2; exp_idle = 5;
        start_layer(1'b1, 1'b1, 2, 1, 16'h0300, 2);
        check_s("t2_col", 32'(bus.col), 1);
        wait_done("t2", 200, dcyc);
        check_s("t2_done_latency", dcyc - last_rd_cyc, 5);
        check_s("t2_bursts", burst_cnt - b0, 2);
        post_done("t2", d0, 1'b0);

        // rows=0: no reads, busy one cycle, done two cycles after start
        d0 = done_cnt;
        start_layer(1'b1, 1'b0, 0, 8, 16'h0500, 0);
        check_s("t3_busy", 32'(bus.busy), 1);
        check_s("t3_rd_en", 32'(bus.rd_en), 0);
        check_s("t3_done_early", 32'(bus.done), 0);
        @(negedge clk);
        check_s("t3_done", 32'(bus.done), 1);
        check_s("t3_busy_off", 32'(bus.busy), 0);
        post_done("t3", d0, 1'b0);

        // rows=3, cols=4: pool_end only for row 0 -> timeout after row 1
        d0 = done_cnt; b0 = burst_cnt;
        pe_dly = 1; pe_budget = 1; exp_idle = 5;
        start_layer(1'b1, 1'b0, 3, 4, 16'h0400, 2);
        wait_done("t4", 200, dcyc);
        check_s("t4_timeout_latency", dcyc - last_rd_cyc, 17);
        check_s("t4_bursts", burst_cnt - b0, 2);
        post_done("t4", d0, 1'b1);
        repeat (4) @(negedge clk);
        check_s("t4_err_sticky", 32'(bus.err), 1);

        // base 0xFFFE, rows=1, cols=4: address wrap; start clears err
        d0 = done_cnt;
        pe_dly = 1; pe_budget = 1;
        addr_q.push_back(16'hFFFE); data_q.push_back(mem_word(16'hFFFE));
        addr_q.push_back(16'hFFFF); data_q.push_back(mem_word(16'hFFFF));
        addr_q.push_back(16'h0000); data_q.push_back(mem_word(16'h0000));
        addr_q.push_back(16'h0001); data_q.push_back(mem_word(16'h0001));
        start_layer(1'b0, 1'b0, 1, 4, 16'hFFFE, 0);
        check_s("t5_err_cleared", 32'(bus.err), 0);
        wait_done("t5", 200, dcyc);
        check_s("t5_done_latency", dcyc - last_rd_cyc, 5);
        post_done("t5", d0, 1'b0);

        // rows=4, cols=8: stray start mid-layer, then reset in the 2nd burst
        d0 = done_cnt; b0 = burst_cnt;
        pe_dly = 3; pe_budget = 100; exp_idle = 7;
        start_layer(1'b1, 1'b1, 4, 8, 16'h0200, 4);
        repeat (12) @(negedge clk);
        bus.cfg_rows  = DW'(1);
        bus.cfg_cols  = DW'(2);
        bus.cfg_base  = '0;
        bus.cfg_start = 1'b1;
        @(negedge clk);
        bus.cfg_start = 1'b0;
        check_s("t6_col_held", 32'(bus.col), 8);
        check_s("t6_busy_held", 32'(bus.busy), 1);
        for (int i = 0; i < 60 && burst_cnt < b0 + 2; i++) @(negedge clk);
        check_s("t6_second_burst", burst_cnt - b0, 2);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("t6_async_reset");
        pe_budget = 0;
        addr_q.delete();
        data_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_s("t6_no_done", done_cnt - d0, 0);
        check_s("t6_idle_busy", 32'(bus.busy), 0);
        check_s("t6_idle_rd_en", 32'(bus.rd_en), 0);

        // recovery after reset: pool_en=0, layer1=1
        d0 = done_cnt;
        pe_dly = 0; pe_budget = 1;
        start_layer(1'b0, 1'b1, 1, 2, 16'h0040, 1);
        check_s("t7_pool_en", 32'(bus.pool_en), 0);
        check_s("t7_layer1", 32'(bus.layer1), 1);
        check_s("t7_col", 32'(bus.col), 2);
        wait_done("t7", 200, dcyc);
        check_s("t7_done_latency", dcyc - last_rd_cyc, 5);
        post_done("t7", d0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/pool_seq_ctrl.md
Name: pool_seq_ctrl

Overview:
- Sequences the max-pool datapath over a full feature map stored in the on-chip feature buffer.
- Latches a layer configuration on a start pulse and reads the map row by row from the buffer.
- Drives each row to the pool block as one contiguous valid burst of cols beats, then waits for the pool block's end pulse before issuing the next row.
- Sits between the layer controller (cfg/start/done) and the pool datapath plus feature buffer read port.

Parameters:
ADDR_W  16  feature buffer word-address width
DIM_W  16  width of row/column counts
GAP  2  minimum idle cycles between bursts (must be >=2; pool block detects start on a valid rising edge)
TMO_W  12  width of the pool_end timeout counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_start  in  1  one-cycle start pulse
cfg_pool_en  in  1  pooling enabled for this layer
cfg_layer1  in  1  layer-1 output format select
cfg_rows  in  DIM_W  number of input rows
cfg_cols  in  DIM_W  beats per row
cfg_base  in  ADDR_W  buffer address of row 0, beat 0
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse, layer finished
err  out  1  sticky timeout flag; cleared on next accepted start
rd_en  out  1  feature buffer read strobe
rd_addr  out  ADDR_W  feature buffer read address
rd_data  in  256  buffer read data, valid exactly 1 cycle after rd_en
pool_en  out  1  to pool block, latched cfg_pool_en
layer1  out  1  to pool block, latched cfg_layer1
col  out  16  to pool block, latched cfg_cols
valid_in  out  1  to pool block, rd_en delayed 1 cycle
data_in  out  256  to pool block, rd_data passed through combinationally
pool_end  in  1  end pulse from pool block

Behaviour:
- Reset (async, rst_n=0): state=IDLE. busy, done, err, rd_en, valid_in, pool_en and layer1 are 0. rd_addr=0, col=0. All counters are 0. Reset mid-layer aborts immediately with no done pulse.
- FSM states: IDLE, ISSUE, GAP, WAIT_END, FINISH.
- IDLE:
  - cfg_start=1 latches all cfg_*, sets busy=1 and clears err.
  - If cfg_rows==0 or cfg_cols==0, go to FINISH with no reads.
  - Otherwise go to ISSUE with row=0, beat=0, addr=cfg_base.
- ISSUE:
  - rd_en=1 and rd_addr=addr every cycle; addr increments by 1 each cycle, modulo 2^ADDR_W (wrap allowed, not flagged).
  - beat counts 0..cols-1. On beat==cols-1, go to GAP. The burst is exactly cols consecutive rd_en cycles.
- valid_in is a registered copy of rd_en, so it is high for exactly cols consecutive cycles, 1 cycle after rd_en. data_in=rd_data.
- GAP: hold GAP cycles with rd_en=0, then go to WAIT_END. The timeout counter starts at GAP entry.
- WAIT_END:
  - On pool_end=1: row increments. If row==rows-1 (pre-increment), go to FINISH; else go to GAP2. GAP2 is a second GAP pass that returns to ISSUE.
  - Implementation: GAP carries a "next" flag selecting WAIT_END or ISSUE.
  - A pool_end arriving while in ISSUE or GAP is also captured (pending flag) and consumed on WAIT_END entry.
  - Timeout: if 2^TMO_W-1 cycles elapse without pool_end, set err=1 and go to FINISH.
- FINISH: done=1 for one cycle, busy=0, then IDLE. pool_en, layer1 and col hold their latched values until the next start.
- cfg_start while busy=1 is ignored; there is no queuing.
- pool_end outside busy is ignored.
- pool_en=0 layers follow the same sequencing; the pool block then returns its bypass end pulse, 1 cycle after the burst.
- Latency:
  - start to first rd_en: 1 cycle.
  - done: 1 cycle after the last row's pool_end is accepted.

Test Plan:
- rows=4, cols=8, base=0x0100, pool_en=1 -> 4 bursts of 8 rd_en cycles. Addresses 0x0100..0x011F contiguous; valid_in is each burst delayed 1 cycle. At least GAP idle cycles between bursts. Exactly one done after the 4th pool_end; err=0.
- rows=2, cols=1 -> two single-cycle bursts separated by gaps; pool block receives col=1; done asserted once.
- rows=0, cols=8 -> no rd_en, done 2 cycles after start, busy high 1 cycle.
- rows=3, cols=4 with pool_end held low after row 1 and TMO_W=4 -> err=1 after 15 cycles in GAP/WAIT_END, done pulse, no further reads. The next start clears err.
- base=0xFFFE, rows=1, cols=4 -> rd_addr sequence FFFE, FFFF, 0000, 0001.
- rst_n dropped during the 2nd burst of rows=4, cols=8 -> all outputs 0 asynchronously, no done. cfg_start pulsed mid-layer (with reset not asserted) has no effect on sequencing.
